fp_sub_seq: RTL and testbench



---
 rtl/fp_pkg.sv | 39 +++
 rtl/fp_unpack_align.sv | 37 +++
 rtl/fp_sub_seq.sv | 146 ++++++++++++++
 tb/tb_fp_sub_seq.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential single-precision subtractor.
package fp_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MAN_W  = 23;
    localparam int unsigned BIAS   = 127;
    localparam int unsigned WORD_W = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = MAN_W + 1;

    // Unpacked operand: the mantissa carries the hidden bit at [MAN_W].
    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   man;
    } fp_unpacked_t;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        DONE
    } state_t;

    // Denormals are read with exponent 1 and a hidden bit of 0.
    function automatic fp_unpacked_t fp_unpack(input logic [WORD_W-1:0] w);
        fp_unpacked_t u;
        u.sign = w[WORD_W-1];
        u.exp  = w[WORD_W-2:MAN_W];
        if (u.exp == '0) begin
            u.exp = EXP_W'(1);
            u.man = {1'b0, w[MAN_W-1:0]};
        end else begin
            u.man = {1'b1, w[MAN_W-1:0]};
        end
        return u;
    endfunction

endpackage

// File: rtl/fp_unpack_align.sv
// Combinational unpack, magnitude ordering and alignment shift for the ALIGN step.
module fp_unpack_align
    import fp_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    output logic              o_x_sign,
    output logic [EXP_W-1:0]  o_x_exp,
    output logic [MAN_W:0]    o_x_man,
    output logic              o_y_sign,
    output logic [MAN_W:0]    o_y_man
);

    fp_unpacked_t     w_ua;
    fp_unpacked_t     w_ub;
    fp_unpacked_t     w_x;
    fp_unpacked_t     w_y;
    logic             w_a_ge_b;
    logic [EXP_W-1:0] w_diff;

    assign w_ua = fp_unpack(i_a);
    assign w_ub = fp_unpack(i_b);

    // X gets the larger (exponent, mantissa) pair so the later subtraction never goes negative.
    assign w_a_ge_b = {w_ua.exp, w_ua.man} >= {w_ub.exp, w_ub.man};
    assign w_x      = w_a_ge_b ? w_ua : w_ub;
    assign w_y      = w_a_ge_b ? w_ub : w_ua;
    assign w_diff   = w_x.exp - w_y.exp;

    assign o_x_sign = w_x.sign;
    assign o_x_exp  = w_x.exp;
    assign o_x_man  = w_x.man;
    assign o_y_sign = w_y.sign;
    // Shifts of a full significand width or more flush Y entirely.
    assign o_y_man  = (w_diff >= EXP_W'(SIG_W)) ? '0 : (w_y.man >> w_diff);

endmodule

// File: rtl/fp_sub_seq.sv
// Multi-cycle single-precision subtractor (A - B), truncating, one-bit-per-cycle normalisation.
module fp_sub_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [EXP_W+MAN_W:0]     i_a,
    input  logic [EXP_W+MAN_W:0]     i_b,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [EXP_W+MAN_W:0]     o_result,
    output logic                     o_busy
);

    import fp_pkg::*;

    localparam int unsigned WordW = 1 + EXP_W + MAN_W;

    state_t             r_state;
    logic [WordW-1:0]   r_a;
    logic [WordW-1:0]   r_b;
    logic               r_sign;
    logic               r_y_sign;
    logic [EXP_W-1:0]   r_exp;
    logic [MAN_W:0]     r_x_man;
    logic [MAN_W:0]     r_y_man;
    logic [MAN_W+1:0]   r_m;
    logic [WordW-1:0]   r_result;
    logic               r_out_valid;
    logic               r_in_ready;
    logic               r_busy;

    logic               w_x_sign;
    logic [EXP_W-1:0]   w_x_exp;
    logic [MAN_W:0]     w_x_man;
    logic               w_y_sign;
    logic [MAN_W:0]     w_y_man;
    logic [MAN_W+1:0]   w_sum;
    logic [EXP_W-1:0]   w_exp_inc;
    logic [EXP_W-1:0]   w_exp_field;

    fp_unpack_align u_align (
        .i_a      (r_a),
        .i_b      (r_b),
        .o_x_sign (w_x_sign),
        .o_x_exp  (w_x_exp),
        .o_x_man  (w_x_man),
        .o_y_sign (w_y_sign),
        .o_y_man  (w_y_man)
    );

    // Magnitude add for like signs, subtract otherwise; X >= Y keeps the difference non-negative.
    assign w_sum = (r_sign == r_y_sign) ? ({1'b0, r_x_man} + {1'b0, r_y_man})
                                        : ({1'b0, r_x_man} - {1'b0, r_y_man});
    // Carry-out exponent wraps rather than saturating.
    assign w_exp_inc   = r_exp + EXP_W'(1);
    // A significand still lacking its hidden bit at exit is a denormal.
    assign w_exp_field = r_m[MAN_W] ? r_exp : '0;

    // Control FSM and datapath registers; outputs are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sign      <= 1'b0;
            r_y_sign    <= 1'b0;
            r_exp       <= '0;
            r_x_man     <= '0;
            r_y_man     <= '0;
            r_m         <= '0;
            r_result    <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid && r_in_ready) begin
                        r_a        <= i_a;
                        // Negating B turns the operation into A + (-B).
                        r_b        <= {~i_b[WordW-1], i_b[WordW-2:0]};
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_sign   <= w_x_sign;
                    r_y_sign <= w_y_sign;
                    r_exp    <= w_x_exp;
                    r_x_man  <= w_x_man;
                    r_y_man  <= w_y_man;
                    r_state  <= ADD;
                end
                ADD: begin
                    r_m     <= w_sum;
                    r_state <= NORM;
                end
                NORM: begin
                    if (r_m[MAN_W+1]) begin
                        r_m         <= r_m >> 1;
                        r_exp       <= w_exp_inc;
                        r_result    <= {r_sign, w_exp_inc, r_m[MAN_W:1]};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (r_m == '0) begin
                        // Exact cancellation always yields +0.
                        r_sign      <= 1'b0;
                        r_exp       <= '0;
                        r_result    <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (!r_m[MAN_W] && (r_exp > EXP_W'(1))) begin
                        r_m   <= r_m << 1;
                        r_exp <= r_exp - EXP_W'(1);
                    end else begin
                        r_result    <= {r_sign, w_exp_field, r_m[MAN_W-1:0]};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_result    = r_result;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Scoreboard bench for fp_sub_seq: directed cases, back-pressure, mid-operation reset, random traffic.
module tb_fp_sub_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_result;
    logic        o_busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];

    fp_sub_seq dut (
        .clk         (clk),
        .rst         (rst),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: exact arithmetic on integer significands, normalised by locating the leading one.
    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b,
                                            output int lsh);
        int ea, eb, ma, mb, ex, ey, mx, my, d, sum, p, e;
        bit sa, sb, sx, sy;
        sa = a[31];
        sb = !b[31];
        ea = (a[30:23] == 8'd0) ? 1 : int'(a[30:23]);
        eb = (b[30:23] == 8'd0) ? 1 : int'(b[30:23]);
        ma = int'(a[22:0]) + ((a[30:23] == 8'd0) ? 0 : (1 << 23));
        mb = int'(b[22:0]) + ((b[30:23] == 8'd0) ? 0 : (1 << 23));
        if (ea > eb || (ea == eb && ma >= mb)) begin
            sx = sa; ex = ea; mx = ma; sy = sb; ey = eb; my = mb;
        end else begin
            sx = sb; ex = eb; mx = mb; sy = sa; ey = ea; my = ma;
        end
        d   = ex - ey;
        my  = (d >= 24) ? 0 : (my >> d);
        sum = (sx == sy) ? (mx + my) : (mx - my);
        lsh = 0;
        if (sum == 0) return 32'h0;
        if (sum >= (1 << 24)) begin
            e = (ex + 1) % 256;
            return {sx, e[7:0], sum[23:1]};
        end
        p = 0;
        for (int i = 0; i < 24; i++) if (((sum >> i) & 1) == 1) p = i;
        lsh = 23 - p;
        if (lsh > ex - 1) lsh = ex - 1;
        e   = ex - lsh;
        sum = sum << lsh;
        return {sx, (sum[23] ? e[7:0] : 8'd0), sum[22:0]};
    endfunction

    // Issue one operand pair; the expectation is queued on the cycle the DUT takes it.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input int exp_lat);
        bit ok = 1'b0;
        @(posedge clk); #1;
        i_in_valid = 1'b1;
        i_a        = a;
        i_b        = b;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(negedge clk);
            if (o_in_ready) begin
                exp_q.push_back(exp_res);
                lat_q.push_back(exp_lat);
                acc_q.push_back(cyc + 1);
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL accept_timeout a=%h b=%h actual=not_accepted required=accepted", a, b);
        end
    endtask

    task automatic send_model(input logic [31:0] a, input logic [31:0] b);
        int          l;
        logic [31:0] r;
        r = ref_sub(a, b, l);
        send(a, b, r, 3 + l);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !o_out_valid) done = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL drain_timeout actual=pending=%0d required=pending=0", exp_q.size());
        end
    endtask

    // Consumer back-pressure, updated just after each rising edge.
    initial begin
        i_out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       i_out_ready = ($urandom_range(3) != 0);
                1:       i_out_ready = 1'b0;
                default: i_out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: checks value and latency when a result appears, pops on handshake.
    initial begin
        bit seen = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                seen = 1'b0;
            end else if (o_out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output actual=%h required=no_output", o_result);
                end else if (!seen) begin
                    check32("result", o_result, exp_q[0]);
                    check32("latency", 32'(cyc - acc_q[0]), 32'(lat_q[0]));
                end else begin
                    check32("result_hold", o_result, exp_q[0]);
                end
                seen = 1'b1;
                if (i_out_ready) begin
                    seen = 1'b0;
                    if (exp_q.size() > 0) begin
                        void'(exp_q.pop_front());
                        void'(lat_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        bit          got;
        rst        = 1'b1;
        i_in_valid = 1'b0;
        i_a        = 32'h0;
        i_b        = 32'h0;
        repeat (3) @(negedge clk);
        check32("rst_in_ready", 32'(o_in_ready), 32'd1);
        check32("rst_out_valid", 32'(o_out_valid), 32'd0);
        check32("rst_result", o_result, 32'h0);
        check32("rst_busy", 32'(o_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3);  // 3.0 - 1.0
        send(32'h3F80_0000, 32'h3F40_0000, 32'h3E80_0000, 5);  // 1.0 - 0.75
        send(32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3);  // carry path
        send(32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3);  // exact zero
        send(32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 4);  // 1.0 - 2.0
        send(32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 3);  // exponent gap 24
        send(32'h0000_0002, 32'h0000_0001, 32'h0000_0001, 3);  // denormal result
        send(32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7FFF_FFFF, 3);  // exponent wraps to 255
        wait_drain();

        // Back-pressure: result held, second operand ignored
        rdy_mode = 1;
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3);
        got = 1'b0;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (o_out_valid) got = 1'b1;
        end
        for (int i = 0; i < 10; i++) begin
            check32("hold_out_valid", 32'(o_out_valid), 32'd1);
            check32("hold_result", o_result, 32'h4000_0000);
            check32("hold_in_ready", 32'(o_in_ready), 32'd0);
            if (i == 0) begin
                i_in_valid = 1'b1;
                i_a        = 32'h3F80_0000;
                i_b        = 32'h3F40_0000;
            end
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        rdy_mode   = 2;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check32("release_out_valid", 32'(o_out_valid), 32'd0);
        check32("release_in_ready", 32'(o_in_ready), 32'd1);
        repeat (6) @(negedge clk);
        check32("ignored_out_valid", 32'(o_out_valid), 32'd0);
        check32("ignored_busy", 32'(o_busy), 32'd0);

        // Asynchronous reset while normalising 1.0 - 0.75
        @(posedge clk); #1;
        i_in_valid = 1'b1;
        i_a        = 32'h3F80_0000;
        i_b        = 32'h3F40_0000;
        @(negedge clk);
        check32("abort_accept_ready", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check32("abort_busy_before", 32'(o_busy), 32'd1);
        rst = 1'b1;
        #1;
        check32("abort_out_valid", 32'(o_out_valid), 32'd0);
        check32("abort_in_ready", 32'(o_in_ready), 32'd1);
        check32("abort_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send(32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3);
        wait_drain();

        // Random traffic with random back-pressure
        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(3))
                0: ;
                1: rb = {1'($urandom_range(1)), ra[30:23], 23'($urandom)};
                2: rb = ra ^ ($urandom & 32'h8000_0FFF);
                default: begin
                    ra = {ra[31], 8'($urandom_range(2)), ra[22:0]};
                    rb = {rb[31], 8'($urandom_range(2)), rb[22:0]};
                end
            endcase
            send_model(ra, rb);
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
